// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: segment bit order,
// the all-dark pattern and the hex-to-segment decode.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;

  localparam logic [6:0] M_A = 7'(1) << SEG_A;
  localparam logic [6:0] M_B = 7'(1) << SEG_B;
  localparam logic [6:0] M_C = 7'(1) << SEG_C;
  localparam logic [6:0] M_D = 7'(1) << SEG_D;
  localparam logic [6:0] M_E = 7'(1) << SEG_E;
  localparam logic [6:0] M_F = 7'(1) << SEG_F;
  localparam logic [6:0] M_G = 7'(1) << SEG_G;

  // Active-high segment set {a..g}; callers invert for the active-low pins.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] r;
    r = '0;
    unique case (nib)
      4'h0: r = M_A | M_B | M_C | M_D | M_E | M_F;
      4'h1: r = M_B | M_C;
      4'h2: r = M_A | M_B | M_D | M_E | M_G;
      4'h3: r = M_A | M_B | M_C | M_D | M_G;
      4'h4: r = M_B | M_C | M_F | M_G;
      4'h5: r = M_A | M_C | M_D | M_F | M_G;
      4'h6: r = M_A | M_C | M_D | M_E | M_F | M_G;
      4'h7: r = M_A | M_B | M_C;
      4'h8: r = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
      4'h9: r = M_A | M_B | M_C | M_D | M_F | M_G;
      4'hA: r = M_A | M_B | M_C | M_E | M_F | M_G;
      4'hB: r = M_C | M_D | M_E | M_F | M_G;
      4'hC: r = M_A | M_D | M_E | M_F;
      4'hD: r = M_B | M_C | M_D | M_E | M_G;
      4'hE: r = M_A | M_D | M_E | M_F | M_G;
      4'hF: r = M_A | M_E | M_F | M_G;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan timebase: PWM phase within a digit slot, digit index, frame markers
// and the blink phase that flips every BLINK_FRAMES frames.
module seg7_scan_timer #(
  parameter int N_DIGITS     = 8,
  parameter int SLOT_CYCLES  = 32768,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  output logic [$clog2(N_DIGITS)-1:0] o_idx,
  output logic [PWM_BITS-1:0]         o_phase,
  output logic                        o_frame_first,
  output logic                        o_frame_last,
  output logic                        o_blink_on
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int SUB   = SLOT_CYCLES >> PWM_BITS;
  localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'(SUB - 1);
  localparam logic [PWM_BITS-1:0] PH_LAST  = '1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BF_W-1:0]     BF_LAST  = BF_W'(BLINK_FRAMES - 1);

  // slot_cnt is kept split as {phase, sub}: phase is the top PWM_BITS of the
  // slot position even when SLOT_CYCLES is not a power of two.
  logic [SUB_W-1:0]    r_sub;
  logic [PWM_BITS-1:0] r_phase;
  logic [IDX_W-1:0]    r_idx;
  logic [BF_W-1:0]     r_blink_cnt;
  logic                r_blink_on;

  logic w_phase_end;
  logic w_slot_end;
  logic w_frame_end;

  assign w_phase_end = (r_sub == SUB_LAST);
  assign w_slot_end  = w_phase_end && (r_phase == PH_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sub       <= '0;
      r_phase     <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      r_sub <= w_phase_end ? '0 : r_sub + SUB_W'(1);
      if (w_phase_end) begin
        r_phase <= r_phase + PWM_BITS'(1);
      end
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
      // Blink phase only moves on frame edges so a frame is never half-blinked.
      if (w_frame_end) begin
        if (r_blink_cnt == BF_LAST) begin
          r_blink_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BF_W'(1);
        end
      end
    end
  end

  assign o_idx         = r_idx;
  assign o_phase       = r_phase;
  assign o_frame_first = (r_sub == '0) && (r_phase == '0) && (r_idx == '0);
  assign o_frame_last  = w_frame_end;
  assign o_blink_on    = r_blink_on;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed common-anode 7-segment driver with frame-aligned
// shadow/active content swap, masking, leading-zero blanking and PWM dimming.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SLOT_CYCLES  = 32768,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    cclk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   val,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic [N_DIGITS-1:0]     blank_mask,
  input  logic [N_DIGITS-1:0]     blink_mask,
  input  logic                    lz_blank,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [7:0]              seg,
  output logic [N_DIGITS-1:0]     dig
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [IDX_W-1:0]    w_idx;
  logic [PWM_BITS-1:0] w_phase;
  logic                w_frame_first;
  logic                w_frame_last;
  logic                w_blink_on;

  seg7_scan_timer #(
    .N_DIGITS     (N_DIGITS),
    .SLOT_CYCLES  (SLOT_CYCLES),
    .PWM_BITS     (PWM_BITS),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .i_clk         (cclk),
    .i_rst_n       (rst_n),
    .o_idx         (w_idx),
    .o_phase       (w_phase),
    .o_frame_first (w_frame_first),
    .o_frame_last  (w_frame_last),
    .o_blink_on    (w_blink_on)
  );

  logic [4*N_DIGITS-1:0] r_sh_val;
  logic [N_DIGITS-1:0]   r_sh_dp;
  logic [N_DIGITS-1:0]   r_sh_blank;
  logic [N_DIGITS-1:0]   r_sh_blink;
  logic                  r_sh_lz;
  logic                  r_pending;

  logic [4*N_DIGITS-1:0] r_act_val;
  logic [N_DIGITS-1:0]   r_act_dp;
  logic [N_DIGITS-1:0]   r_act_blank;
  logic [N_DIGITS-1:0]   r_act_blink;
  logic                  r_act_lz;
  logic                  r_applied;

  // Handshake: valid is load (single-cycle capture, no ready -- the shadow
  // always accepts, last load before a frame boundary wins). The swap happens
  // on the frame's last cycle, so the new content is first emitted together
  // with frame_start; a load on that same cycle waits for the next boundary.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_val    <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_sh_blink  <= '0;
      r_sh_lz     <= 1'b0;
      r_pending   <= 1'b0;
      r_act_val   <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_act_blink <= '0;
      r_act_lz    <= 1'b0;
      r_applied   <= 1'b0;
    end else begin
      if (w_frame_last && r_pending) begin
        r_act_val   <= r_sh_val;
        r_act_dp    <= r_sh_dp;
        r_act_blank <= r_sh_blank;
        r_act_blink <= r_sh_blink;
        r_act_lz    <= r_sh_lz;
      end
      if (load) begin
        r_sh_val   <= val;
        r_sh_dp    <= dp_mask;
        r_sh_blank <= blank_mask;
        r_sh_blink <= blink_mask;
        r_sh_lz    <= lz_blank;
      end
      r_pending <= load | (r_pending & ~w_frame_last);
      r_applied <= w_frame_last & r_pending;
    end
  end

  // A digit is zero-suppressed while it and every digit above it hold 0.
  logic [N_DIGITS-1:0] w_lz_sup;
  logic                w_seen_nz;

  always_comb begin
    w_lz_sup  = '0;
    w_seen_nz = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (r_act_val[4*i +: 4] != 4'd0) begin
        w_seen_nz = 1'b1;
      end
      w_lz_sup[i] = r_act_lz & ~w_seen_nz;
    end
  end

  logic [3:0] w_nib;
  logic       w_dp;
  logic       w_blank;
  logic       w_blink;
  logic       w_sup;

  always_comb begin
    w_nib   = '0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    w_blink = 1'b0;
    w_sup   = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_nib   = r_act_val[4*i +: 4];
        w_dp    = r_act_dp[i];
        w_blank = r_act_blank[i];
        w_blink = r_act_blink[i];
        w_sup   = w_lz_sup[i];
      end
    end
  end

  logic                w_dark;
  logic                w_lit;
  logic [7:0]          w_seg_nxt;
  logic [N_DIGITS-1:0] w_dig_nxt;

  assign w_dark = w_blank | (w_blink & ~w_blink_on) | w_sup;
  // Phase 0 is the anti-ghosting guard unless running at full brightness.
  assign w_lit  = (w_phase <= brightness) &&
                  !((w_phase == '0) && (brightness != PWM_MAX));

  // PWM gates only the digit enable; segments keep the digit's pattern.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_dig_nxt = '0;
    if (!w_dark) begin
      w_seg_nxt[SEG_DP]  = ~w_dp;
      w_seg_nxt[6:0]     = ~hex_to_seg(w_nib);
      if (w_lit) begin
        w_dig_nxt[w_idx] = 1'b1;
      end
    end
  end

  logic [7:0]          r_seg;
  logic [N_DIGITS-1:0] r_dig;
  logic                r_frame_start;
  logic                r_load_ack;

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg         <= SEG_OFF;
      r_dig         <= '0;
      r_frame_start <= 1'b0;
      r_load_ack    <= 1'b0;
    end else begin
      r_seg         <= w_seg_nxt;
      r_dig         <= w_dig_nxt;
      r_frame_start <= w_frame_first;
      r_load_ack    <= r_applied;
    end
  end

  assign seg         = r_seg;
  assign dig         = r_dig;
  assign frame_start = r_frame_start;
  assign load_ack    = r_load_ack;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: reference model predicts every output cycle into
// a queue; an independent monitor pops and compares after each clock edge.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int SLOT = 32;
  localparam int PB = 2;
  localparam int BF = 2;
  localparam int FL = N * SLOT;
  localparam int W  = 8 + N + 2;

  logic           cclk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*N-1:0] val = '0;
  logic [N-1:0]   dp_mask = '0;
  logic [N-1:0]   blank_mask = '0;
  logic [N-1:0]   blink_mask = '0;
  logic           lz_blank = 1'b0;
  logic [PB-1:0]  brightness = 2'd3;
  logic           load = 1'b0;
  logic           load_ack;
  logic           frame_start;
  logic [7:0]     seg;
  logic [N-1:0]   dig;

  seg7_scan_ctrl #(
    .N_DIGITS     (N),
    .SLOT_CYCLES  (SLOT),
    .PWM_BITS     (PB),
    .BLINK_FRAMES (BF)
  ) dut (
    .cclk        (cclk),
    .rst_n       (rst_n),
    .val         (val),
    .dp_mask     (dp_mask),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
    .load        (load),
    .load_ack    (load_ack),
    .frame_start (frame_start),
    .seg         (seg),
    .dig         (dig)
  );

  always #5 cclk = ~cclk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state: cycles since reset, shadow/active content.
  int             m_k = 0;
  logic [4*N-1:0] m_val = '0, s_val = '0;
  logic [N-1:0]   m_dp = '0, s_dp = '0;
  logic [N-1:0]   m_bl = '0, s_bl = '0;
  logic [N-1:0]   m_bk = '0, s_bk = '0;
  logic           m_lz = 1'b0, s_lz = 1'b0;
  bit             m_pending = 0;
  bit             m_applied = 0;

  string seg_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_bits(input int nib);
    logic [6:0] r;
    string s;
    r = '0;
    s = seg_str[nib];
    for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] model_out(input int k, input int br, input bit ack);
    int idx, slot, phase, frame;
    bit blink_off, sup, dark, lit;
    logic [7:0] s;
    logic [N-1:0] d;
    idx   = (k / SLOT) % N;
    slot  = k % SLOT;
    phase = slot * (1 << PB) / SLOT;
    frame = k / FL;
    blink_off = ((frame / BF) % 2) == 1;
    sup  = m_lz && (idx != 0) && ((m_val >> (4 * idx)) == 0);
    dark = m_bl[idx] || (m_bk[idx] && blink_off) || sup;
    lit  = (phase <= br) && !(phase == 0 && br != (1 << PB) - 1);
    s = 8'hFF;
    d = '0;
    if (!dark) begin
      s = {~m_dp[idx], ~seg_bits(int'(m_val[4*idx +: 4]))};
      if (lit) d[idx] = 1'b1;
    end
    return {s, d, (k % FL) == 0, ack};
  endfunction

  // Model: one prediction per rising edge, from the inputs sampled there.
  initial forever begin
    @(posedge cclk);
    if (!rst_n) begin
      m_k = 0; m_pending = 0; m_applied = 0;
      m_val = '0; m_dp = '0; m_bl = '0; m_bk = '0; m_lz = 0;
      s_val = '0; s_dp = '0; s_bl = '0; s_bk = '0; s_lz = 0;
      exp_q.push_back({8'hFF, {N{1'b0}}, 2'b00});
    end else begin
      exp_q.push_back(model_out(m_k, int'(brightness), m_applied));
      m_applied = 0;
      if ((m_k % FL) == FL - 1) begin
        if (m_pending) begin
          m_val = s_val; m_dp = s_dp; m_bl = s_bl; m_bk = s_bk; m_lz = s_lz;
          m_applied = 1;
        end
        m_pending = 0;
      end
      if (load) begin
        s_val = val; s_dp = dp_mask; s_bl = blank_mask; s_bk = blink_mask; s_lz = lz_blank;
        m_pending = 1;
      end
      m_k++;
    end
  end

  // Monitor: compares the registered outputs shortly after each edge.
  initial forever begin
    logic [W-1:0] e;
    @(posedge cclk);
    #1;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty t=%0t: no expected entry for observed output", $time);
    end else begin
      e = exp_q.pop_front();
      if ({seg, dig, frame_start, load_ack} !== e) begin
        miscompares++;
        $display("FAIL out t=%0t: got seg=%h dig=%b fs=%b ack=%b, expected seg=%h dig=%b fs=%b ack=%b",
                 $time, seg, dig, frame_start, load_ack, e[W-1 -: 8], e[N+1:2], e[1], e[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge cclk);
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] dp,
                         input logic [N-1:0] bl, input logic [N-1:0] bk, input logic lz);
    @(negedge cclk);
    val = v; dp_mask = dp; blank_mask = bl; blink_mask = bk; lz_blank = lz;
    load = 1'b1;
    @(negedge cclk);
    load = 1'b0;
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * FL && !seen; i++) begin
      @(negedge cclk);
      if (frame_start) seen = 1;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL fs_timeout: no frame_start within %0d cycles, expected one", 2 * FL);
    end
  endtask

  task automatic do_reset();
    @(negedge cclk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (seg !== 8'hFF || dig !== '0) begin
      miscompares++;
      $display("FAIL async_reset: seg=%h dig=%b, expected seg=ff dig=0", seg, dig);
    end
    tick(3);
    rst_n = 1'b1;
    @(negedge cclk);
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL first_fs: frame_start=%b one cycle after release, expected 1", frame_start);
    end
  endtask

  task automatic check_duty(input int exp_on);
    int cnt [N];
    for (int i = 0; i < N; i++) cnt[i] = 0;
    wait_fs();
    for (int c = 0; c < FL; c++) begin
      for (int i = 0; i < N; i++) if (dig[i]) cnt[i]++;
      @(negedge cclk);
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (cnt[i] != exp_on) begin
        miscompares++;
        $display("FAIL duty d%0d: on %0d cycles, expected %0d", i, cnt[i], exp_on);
      end
    end
  endtask

  initial begin
    int acks;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    do_reset();

    // Decode and scan order.
    do_load(16'hAB09, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_fs();
    tick(2 * FL);

    // Pending load is discarded by a reset before the boundary.
    wait_fs();
    tick(10);
    do_load(16'h1234, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    tick(5);
    do_reset();
    tick(FL + 20);

    // Two loads in one frame: one ack, last content shown.
    wait_fs();
    tick(20);
    do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(30);
    do_load(16'h5678, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    acks = 0;
    for (int c = 0; c < FL + 4; c++) begin
      @(negedge cclk);
      if (load_ack) acks++;
    end
    vectors++;
    if (acks != 1) begin
      miscompares++;
      $display("FAIL ack_count: %0d load_ack pulses, expected 1", acks);
    end
    tick(FL);

    // Leading-zero suppression.
    do_load(16'h0070, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    tick(2 * FL);
    do_load(16'h0000, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    tick(2 * FL);
    do_load(16'h1000, 4'b0000, 4'b0010, 4'b0000, 1'b1);
    tick(2 * FL);

    // Brightness duty.
    do_load(16'h4321, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    brightness = 2'd1;
    tick(FL + 4);
    check_duty(8);
    brightness = 2'd2;
    check_duty(16);
    brightness = 2'd3;
    check_duty(32);

    // Blink from a fresh reset so frame numbering starts at 0.
    do_reset();
    do_load(16'h4321, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    tick(9 * FL);

    // Load landing exactly on the frame-boundary cycle.
    for (int i = 0; i <= FL && (m_k % FL) != FL - 1; i++) @(negedge cclk);
    val = 16'hC0DE; dp_mask = 4'b1000; blank_mask = '0; blink_mask = '0; lz_blank = 1'b0;
    load = 1'b1;
    @(negedge cclk);
    load = 1'b0;
    tick(2 * FL + 10);

    // Randomized loads and brightness changes.
    for (int n = 0; n < 40; n++) begin
      logic [N-1:0] bl, bk;
      bl = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      bk = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      do_load((4*N)'($urandom), N'($urandom_range(0, 15)), bl, bk, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) brightness = PB'($urandom_range(1, 3));
      tick($urandom_range(0, 150));
    end
    tick(2 * FL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
